// File: rtl/snake_head_stepper_pkg.sv
// -----------------------------------------------------------------------------
// snake_head_stepper_pkg
// Shared definitions for the snake head stepper and its neighbours (body,
// collision and renderer blocks): direction codes, FSM state codes, default
// grid dimensions and small direction helpers.
// -----------------------------------------------------------------------------
package snake_head_stepper_pkg;

   localparam int GRID_W_DEF  = 40;
   localparam int GRID_H_DEF  = 30;
   localparam int START_X_DEF = 20;
   localparam int START_Y_DEF = 15;

   // Direction codes are chosen so that the opposite direction is code ^ 2.
   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_UP    = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   // 180-degree reversal of a direction.
   function automatic dir_e opposite_dir(input dir_e d);
      return dir_e'(d ^ 2'd2);
   endfunction

   // Priority encode held buttons: Up > Down > Left > Right.
   function automatic dir_e encode_request(input logic up, input logic down,
                                           input logic left, input logic right);
      dir_e r;
      if (up) begin
         r = DIR_UP;
      end else if (down) begin
         r = DIR_DOWN;
      end else if (left) begin
         r = DIR_LEFT;
      end else if (right) begin
         r = DIR_RIGHT;
      end else begin
         r = DIR_RIGHT;
      end
      return r;
   endfunction

endpackage

// File: rtl/snake_head_stepper_rise_detect.sv
// -----------------------------------------------------------------------------
// snake_head_stepper_rise_detect
// Rising-edge detector for a level signal synchronous to clk. The history
// flop resets to RESET_VAL so that a source which is already high when reset
// is released does not produce a spurious pulse.
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset
//   sig_in  in   level input
//   pulse   out  sig_in & ~previous(sig_in), combinational from the flop
// -----------------------------------------------------------------------------
module snake_head_stepper_rise_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic pulse
);

   logic sig_d;
   logic sig_q;

   // Next value of the history flop: always the current input.
   always_comb begin
      sig_d = sig_in;
   end

   // History flop, updated every cycle regardless of game state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= RESET_VAL;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign pulse = sig_in & ~sig_q;

endmodule

// File: rtl/snake_head_stepper.sv
// -----------------------------------------------------------------------------
// snake_head_stepper
// Advances the snake head one grid cell per rising edge of the game-rate
// tick while running. Latches the player's direction request between ticks,
// rejects 180-degree reversals against the committed direction, and wraps at
// the grid edges.
// Ports:
//   clkIn                 in   pixel clock, single clock domain
//   rst                   in   asynchronous active-high reset
//   tickIn                in   prescaler level output (game tick)
//   enable                in   1 = run, 0 = pause
//   restart               in   1-cycle pulse: back to start position, IDLE
//   btnUp/Down/Left/Right in   debounced direction request levels
//   headX / headY         out  head column / row (row 0 = top)
//   dir                   out  committed direction (0 R, 1 U, 2 L, 3 D)
//   step                  out  1-cycle pulse: head moved
//   wrapped               out  1-cycle pulse with step on an edge crossing
// -----------------------------------------------------------------------------
module snake_head_stepper
   import snake_head_stepper_pkg::*;
#(
   parameter int GRID_W  = GRID_W_DEF,
   parameter int GRID_H  = GRID_H_DEF,
   parameter int START_X = START_X_DEF,
   parameter int START_Y = START_Y_DEF,
   parameter int X_W     = 6,
   parameter int Y_W     = 5
) (
   input  logic           clkIn,
   input  logic           rst,
   input  logic           tickIn,
   input  logic           enable,
   input  logic           restart,
   input  logic           btnUp,
   input  logic           btnDown,
   input  logic           btnLeft,
   input  logic           btnRight,
   output logic [X_W-1:0] headX,
   output logic [Y_W-1:0] headY,
   output logic [1:0]     dir,
   output logic           step,
   output logic           wrapped
);

   localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
   localparam logic [X_W-1:0] X_START = X_W'(START_X);
   localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);

   state_e         state_q, state_d;
   logic [X_W-1:0] head_x_q, head_x_d;
   logic [Y_W-1:0] head_y_q, head_y_d;
   dir_e           dir_q, dir_d;
   dir_e           pend_q, pend_d;
   logic           step_q, step_d;
   logic           wrapped_q, wrapped_d;

   logic           tick_edge;
   logic           step_go;
   logic           req_valid;
   dir_e           req_dir;

   // Tick history resets high: the prescaler starts high, which must not step.
   snake_head_stepper_rise_detect #(
      .RESET_VAL (1'b1)
   ) u_tick_edge (
      .clk    (clkIn),
      .rst    (rst),
      .sig_in (tickIn),
      .pulse  (tick_edge)
   );

   // Current direction request from the held buttons.
   always_comb begin
      req_valid = btnUp | btnDown | btnLeft | btnRight;
      req_dir   = encode_request(btnUp, btnDown, btnLeft, btnRight);
   end

   // Next-state logic: FSM, position update with wrap, direction latch.
   always_comb begin
      state_d   = state_q;
      head_x_d  = head_x_q;
      head_y_d  = head_y_q;
      dir_d     = dir_q;
      pend_d    = pend_q;
      step_d    = 1'b0;
      wrapped_d = 1'b0;
      step_go   = (state_q == ST_RUN) && enable && tick_edge && !restart;

      if (restart) begin
         // Restart wins over a same-cycle tick edge and any button.
         state_d  = ST_IDLE;
         head_x_d = X_START;
         head_y_d = Y_START;
         dir_d    = DIR_RIGHT;
         pend_d   = DIR_RIGHT;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = enable ? ST_RUN : ST_IDLE;
            ST_RUN:   state_d = enable ? ST_RUN : ST_PAUSE;
            ST_PAUSE: state_d = enable ? ST_RUN : ST_PAUSE;
            default:  state_d = ST_IDLE;
         endcase

         if (step_go) begin
            dir_d  = pend_q;
            step_d = 1'b1;
            // Edge compares come first; the grid is not a power of two.
            case (pend_q)
               DIR_RIGHT: begin
                  if (head_x_q == X_MAX) begin
                     head_x_d  = '0;
                     wrapped_d = 1'b1;
                  end else begin
                     head_x_d  = head_x_q + X_W'(1);
                  end
               end
               DIR_LEFT: begin
                  if (head_x_q == '0) begin
                     head_x_d  = X_MAX;
                     wrapped_d = 1'b1;
                  end else begin
                     head_x_d  = head_x_q - X_W'(1);
                  end
               end
               DIR_UP: begin
                  if (head_y_q == '0) begin
                     head_y_d  = Y_MAX;
                     wrapped_d = 1'b1;
                  end else begin
                     head_y_d  = head_y_q - Y_W'(1);
                  end
               end
               DIR_DOWN: begin
                  if (head_y_q == Y_MAX) begin
                     head_y_d  = '0;
                     wrapped_d = 1'b1;
                  end else begin
                     head_y_d  = head_y_q + Y_W'(1);
                  end
               end
               default: begin
                  head_x_d = head_x_q;
                  head_y_d = head_y_q;
               end
            endcase
         end else if ((state_q == ST_RUN) && req_valid &&
                      (req_dir != opposite_dir(dir_q))) begin
            // Reversal is judged against the committed direction, so a
            // turn-then-reverse sequence within one tick cannot fold back.
            pend_d = req_dir;
         end else begin
            pend_d = pend_q;
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         head_x_q  <= X_START;
         head_y_q  <= Y_START;
         dir_q     <= DIR_RIGHT;
         pend_q    <= DIR_RIGHT;
         step_q    <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         head_x_q  <= head_x_d;
         head_y_q  <= head_y_d;
         dir_q     <= dir_d;
         pend_q    <= pend_d;
         step_q    <= step_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign headX   = head_x_q;
   assign headY   = head_y_q;
   assign dir     = dir_q;
   assign step    = step_q;
   assign wrapped = wrapped_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// -----------------------------------------------------------------------------
// tb_snake_head_stepper
// Directed scenarios with constant expectations, then a long randomized run
// compared cycle by cycle against a behavioural model of the game rules
// (coordinates as integers, moves as dx/dy with modulo wrap).
// -----------------------------------------------------------------------------
module tb_snake_head_stepper;

   localparam int GW = 40;
   localparam int GH = 30;
   localparam int SX = 20;
   localparam int SY = 15;

   logic       clk = 1'b0;
   logic       rst, tick, en, rs, bu, bd, bl, br;
   logic [5:0] hx;
   logic [4:0] hy;
   logic [1:0] d;
   logic       st, wr;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state; mode 0 idle, 1 run, 2 pause
   int m_x, m_y, m_dir, m_pend, m_mode;
   bit m_prev, m_step, m_wrap;

   always #5 clk = ~clk;

   snake_head_stepper dut (
      .clkIn    (clk),
      .rst      (rst),
      .tickIn   (tick),
      .enable   (en),
      .restart  (rs),
      .btnUp    (bu),
      .btnDown  (bd),
      .btnLeft  (bl),
      .btnRight (br),
      .headX    (hx),
      .headY    (hy),
      .dir      (d),
      .step     (st),
      .wrapped  (wr)
   );

   function automatic logic [14:0] pack(input int x, input int y, input int dd,
                                        input bit s, input bit w);
      return {6'(x), 5'(y), 2'(dd), s, w};
   endfunction

   wire [14:0] obs = {hx, hy, d, st, wr};

   task automatic model_reset();
      m_x = SX; m_y = SY; m_dir = 0; m_pend = 0; m_mode = 0;
      m_prev = 1'b1; m_step = 1'b0; m_wrap = 1'b0;
   endtask

   task automatic model_clock();
      bit e;
      int dx, dy, nx, ny, req;
      e      = tick && !m_prev;
      m_prev = tick;
      if (rst) begin
         model_reset();
         return;
      end
      m_step = 1'b0;
      m_wrap = 1'b0;
      if (rs) begin
         m_x = SX; m_y = SY; m_dir = 0; m_pend = 0; m_mode = 0;
         return;
      end
      if (m_mode == 1 && en && e) begin
         m_dir  = m_pend;
         m_step = 1'b1;
         dx = (m_dir == 0) ? 1 : (m_dir == 2) ? -1 : 0;
         dy = (m_dir == 3) ? 1 : (m_dir == 1) ? -1 : 0;
         nx = m_x + dx;
         ny = m_y + dy;
         m_wrap = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
         m_x = (nx + GW) % GW;
         m_y = (ny + GH) % GH;
      end else if (m_mode == 1) begin
         req = bu ? 1 : bd ? 3 : bl ? 2 : br ? 0 : -1;
         if (req >= 0 && req != (m_dir + 2) % 4) m_pend = req;
      end
      if (m_mode == 0 && en)       m_mode = 1;
      else if (m_mode == 1 && !en) m_mode = 2;
      else if (m_mode == 2 && en)  m_mode = 1;
   endtask

   // one clock: inputs already stable, sample outputs 1 time unit later
   task automatic cyc();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   // tick low for two cycles then high for one; the step shows on return
   task automatic game_tick();
      tick = 1'b0; cyc(); cyc();
      tick = 1'b1; cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1; tick = 1'b1; en = 1'b0; rs = 1'b0;
      bu = 1'b0; bd = 1'b0; bl = 1'b0; br = 1'b0;
      cyc(); cyc();
      n_checks++;
      if (obs !== pack(SX, SY, 0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", obs, pack(SX, SY, 0, 1'b0, 1'b0));
      end
      rst = 1'b0;
      cyc();
      n_checks++;
      if (obs !== pack(SX, SY, 0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL reset_release: got %h expected %h", obs, pack(SX, SY, 0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_first_step();
      en = 1'b1; tick = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_checks++;
         if (obs !== pack(SX, SY, 0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL no_step_tick_high: cycle %0d got %h expected %h", i, obs, pack(SX, SY, 0, 1'b0, 1'b0));
         end
      end
      tick = 1'b0; cyc();
      tick = 1'b1; cyc();
      n_checks++;
      if (obs !== pack(21, 15, 0, 1'b1, 1'b0)) begin
         n_fail++;
         $display("FAIL first_step: got %h expected %h", obs, pack(21, 15, 0, 1'b1, 1'b0));
      end
      cyc();
      n_checks++;
      if (obs !== pack(21, 15, 0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL step_one_cycle: got %h expected %h", obs, pack(21, 15, 0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_reversal();
      bl = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         game_tick();
         n_checks++;
         if (obs !== pack(21 + k, 15, 0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL reversal_reject: tick %0d got %h expected %h", k, obs, pack(21 + k, 15, 0, 1'b1, 1'b0));
         end
      end
      bl = 1'b0;
   endtask

   task automatic test_turn();
      tick = 1'b0; bu = 1'b1; cyc();
      bu = 1'b0; bl = 1'b1; cyc();
      tick = 1'b1; cyc();
      n_checks++;
      if (obs !== pack(24, 14, 1, 1'b1, 1'b0)) begin
         n_fail++;
         $display("FAIL turn_up: got %h expected %h", obs, pack(24, 14, 1, 1'b1, 1'b0));
      end
      game_tick();
      n_checks++;
      if (obs !== pack(23, 14, 2, 1'b1, 1'b0)) begin
         n_fail++;
         $display("FAIL turn_left_after: got %h expected %h", obs, pack(23, 14, 2, 1'b1, 1'b0));
      end
      bl = 1'b0;
   endtask

   task automatic test_wrap();
      rst = 1'b1; en = 1'b0; tick = 1'b1; cyc();
      rst = 1'b0; en = 1'b1; cyc();
      for (int k = 1; k <= 19; k++) begin
         game_tick();
         n_checks++;
         if (obs !== pack(SX + k, SY, 0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL walk_right: tick %0d got %h expected %h", k, obs, pack(SX + k, SY, 0, 1'b1, 1'b0));
         end
      end
      game_tick();
      n_checks++;
      if (obs !== pack(0, SY, 0, 1'b1, 1'b1)) begin
         n_fail++;
         $display("FAIL wrap_right: got %h expected %h", obs, pack(0, SY, 0, 1'b1, 1'b1));
      end
      bu = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         game_tick();
         if (k == 1) bu = 1'b0;
         n_checks++;
         if (obs !== pack(0, SY - k, 1, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL walk_up: tick %0d got %h expected %h", k, obs, pack(0, SY - k, 1, 1'b1, 1'b0));
         end
      end
      game_tick();
      n_checks++;
      if (obs !== pack(0, GH - 1, 1, 1'b1, 1'b1)) begin
         n_fail++;
         $display("FAIL wrap_up: got %h expected %h", obs, pack(0, GH - 1, 1, 1'b1, 1'b1));
      end
   endtask

   task automatic test_pause();
      en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         game_tick();
         n_checks++;
         if (obs !== pack(0, GH - 1, 1, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL pause_hold: tick %0d got %h expected %h", k, obs, pack(0, GH - 1, 1, 1'b0, 1'b0));
         end
      end
      en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         n_checks++;
         if (obs !== pack(0, GH - 1, 1, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL resume_no_backlog: cycle %0d got %h expected %h", k, obs, pack(0, GH - 1, 1, 1'b0, 1'b0));
         end
      end
      game_tick();
      n_checks++;
      if (obs !== pack(0, GH - 2, 1, 1'b1, 1'b0)) begin
         n_fail++;
         $display("FAIL resume_step: got %h expected %h", obs, pack(0, GH - 2, 1, 1'b1, 1'b0));
      end
      cyc();
      n_checks++;
      if (obs !== pack(0, GH - 2, 1, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL resume_single: got %h expected %h", obs, pack(0, GH - 2, 1, 1'b0, 1'b0));
      end
   endtask

   task automatic test_restart();
      tick = 1'b0; cyc();
      tick = 1'b1; rs = 1'b1; bd = 1'b1; cyc();
      n_checks++;
      if (obs !== pack(SX, SY, 0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL restart_wins: got %h expected %h", obs, pack(SX, SY, 0, 1'b0, 1'b0));
      end
      // held in IDLE: a down request here must be ignored
      rs = 1'b0; en = 1'b0; cyc();
      bd = 1'b0; en = 1'b1; cyc();
      game_tick();
      n_checks++;
      if (obs !== pack(SX + 1, SY, 0, 1'b1, 1'b0)) begin
         n_fail++;
         $display("FAIL restart_idle: got %h expected %h", obs, pack(SX + 1, SY, 0, 1'b1, 1'b0));
      end
   endtask

   task automatic test_async_reset();
      game_tick();
      #2 rst = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (obs !== pack(SX, SY, 0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected %h", obs, pack(SX, SY, 0, 1'b0, 1'b0));
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_random();
      rst = 1'b1; en = 1'b0; rs = 1'b0; tick = 1'b1;
      bu = 1'b0; bd = 1'b0; bl = 1'b0; br = 1'b0;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         en   = ($urandom_range(0, 19) != 0);
         rs   = ($urandom_range(0, 299) == 0);
         bu   = ($urandom_range(0, 9) == 0);
         bd   = ($urandom_range(0, 9) == 0);
         bl   = ($urandom_range(0, 9) == 0);
         br   = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 2) == 0) tick = ~tick;
         cyc();
         n_checks++;
         if (obs !== pack(m_x, m_y, m_dir, m_step, m_wrap)) begin
            n_fail++;
            $display("FAIL random_model: cycle %0d got %h expected %h", i, obs, pack(m_x, m_y, m_dir, m_step, m_wrap));
         end
      end
   endtask

   initial begin
      rst = 1'b1; tick = 1'b1; en = 1'b0; rs = 1'b0;
      bu = 1'b0; bd = 1'b0; bl = 1'b0; br = 1'b0;
      model_reset();
      test_reset();
      test_first_step();
      test_reversal();
      test_turn();
      test_wrap();
      test_pause();
      test_restart();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
